// File: rtl/mux8to1_tree.sv
// 8-to-1 WIDTH-bit mux built as a 3-level tree of 2-to-1 stages.
// Define MUX8_OUT_REG_EN to register out (1-cycle latency).
module mux8to1_tree #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [WIDTH-1:0] input4,
  input  logic [WIDTH-1:0] input5,
  input  logic [WIDTH-1:0] input6,
  input  logic [WIDTH-1:0] input7,
  input  logic [WIDTH-1:0] input8,
  output logic [WIDTH-1:0] out
);

  function automatic logic [WIDTH-1:0] mux2(
    input logic             s,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return s ? b : a;
  endfunction

  logic [WIDTH-1:0] l0_0;
  logic [WIDTH-1:0] l0_1;
  logic [WIDTH-1:0] l0_2;
  logic [WIDTH-1:0] l0_3;
  logic [WIDTH-1:0] l1_0;
  logic [WIDTH-1:0] l1_1;
  logic [WIDTH-1:0] l2;

  assign l0_0 = mux2(select[0], input1, input2);
  assign l0_1 = mux2(select[0], input3, input4);
  assign l0_2 = mux2(select[0], input5, input6);
  assign l0_3 = mux2(select[0], input7, input8);

  assign l1_0 = mux2(select[1], l0_0, l0_1);
  assign l1_1 = mux2(select[1], l0_2, l0_3);

  assign l2   = mux2(select[2], l1_0, l1_1);

`ifdef MUX8_OUT_REG_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= l2;
    end
  end

  assign out = out_q;
`else
  // Clock only matters for the registered build.
  logic unused_clk;
  assign unused_clk = clk;

  assign out = rst ? '0 : l2;
`endif

endmodule

// File: tb/tb_mux8to1_tree.sv
// Scoreboard bench for mux8to1_tree against an array reference model.
// Covers both builds via MUX8_OUT_REG_EN.
module tb_mux8to1_tree;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   select = 3'd0;
  logic [W-1:0] d [8];
  logic [W-1:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [W-1:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  event chk_ev;

  always #5 clk = ~clk;

  mux8to1_tree #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .select (select),
    .input1 (d[0]),
    .input2 (d[1]),
    .input3 (d[2]),
    .input4 (d[3]),
    .input5 (d[4]),
    .input6 (d[5]),
    .input7 (d[6]),
    .input8 (d[7]),
    .out    (out)
  );

  // Reference: the selected word, or zero while reset is held.
  function automatic logic [W-1:0] model(input logic r, input logic [2:0] s);
    if (r) return '0;
    return d[int'(s)];
  endfunction

  // Wait until a new select/data setting is visible at out.
  task automatic settle();
`ifdef MUX8_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // Monitor: compare out whenever a response is announced.
  initial begin
    sb_t e;
    forever begin
      @(chk_ev);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (out !== e.exp) begin
          errors++;
          $display("FAIL %s out=%h expected=%h", e.name, out, e.exp);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] hold;
    logic [3:0]   nib;
    for (int i = 0; i < 8; i++) d[i] = '0;

    // Reset state
    rst = 1'b1;
    #1;
    expect_out("reset_state", '0);
    rst = 1'b0;
    settle();

    // Walk select over single-bit patterns
    d[0] = 64'd0; d[1] = 64'd1; d[2] = 64'd1; d[3] = 64'd0;
    d[4] = 64'd1; d[5] = 64'd1; d[6] = 64'd0; d[7] = 64'd1;
    for (int s = 0; s < 8; s++) begin
      select = 3'(s);
      settle();
      expect_out($sformatf("walk_sel%0d", s), model(rst, select));
    end

    // Full-width patterns
    for (int n = 1; n <= 8; n++) begin
      nib = 4'(n);
      d[n-1] = {16{nib}};
    end
    select = 3'd5;
    settle();
    expect_out("full_sel5", 64'h6666_6666_6666_6666);
    select = 3'd7;
    settle();
    expect_out("full_sel7", 64'h8888_8888_8888_8888);

    // Data tracking with select held
    select = 3'd2;
    d[2] = 64'h0;
    settle();
    expect_out("track_zero", 64'h0);
    d[2] = 64'hDEAD_BEEF_0000_FFFF;
    settle();
    expect_out("track_new", 64'hDEAD_BEEF_0000_FFFF);

    // Reset overrides selection, release restores it
    d[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    select = 3'd3;
    settle();
    rst = 1'b1;
    #1;
    expect_out("rst_clear", '0);
    d[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    select = 3'd1;
    #1;
    expect_out("rst_hold", '0);
    select = 3'd3;
    rst = 1'b0;
    settle();
    expect_out("rst_release", 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized select/data against the model
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
      select = 3'($urandom_range(0, 7));
      settle();
      expect_out($sformatf("rand%0d_sel%0d", k, select), model(rst, select));
    end

    // Mid-cycle select change and mid-cycle reset
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    select = 3'd0;
    settle();
    @(negedge clk);
    select = 3'd6;
    #1;
`ifdef MUX8_OUT_REG_EN
    expect_out("mid_hold_in1", d[0]);
    @(posedge clk);
    #1;
    expect_out("mid_edge_in7", d[6]);
`else
    expect_out("mid_in7", d[6]);
`endif
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_out("mid_rst", '0);
    rst = 1'b0;
    settle();
    expect_out("mid_rst_release", model(rst, select));

    // Drain scoreboard with a bounded wait
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) #1;
    if (sb_q.size() != 0) begin
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
      errors += sb_q.size();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
